// File: rtl/burst_addr_gen_pkg.sv
// Shared encodings and default widths for the burst read-address generator.
// Defaults follow the 1024-deep sample/label RAMs.
package burst_addr_gen_pkg;

  localparam int LOG_DEPTH    = 10;
  localparam int DEPTH        = 1 << LOG_DEPTH;
  localparam int ADDR_W_DEF   = LOG_DEPTH;
  localparam int LEN_W_DEF    = LOG_DEPTH + 1;  // must hold DEPTH itself
  localparam int STRIDE_W_DEF = 4;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_CIRCULAR = 2'd1,
    MODE_REVERSE  = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/burst_addr_gen_addr_step.sv
// Combinational next-address step: addr +/- stride, wrapping modulo 2^ADDR_W.
module addr_step #(
  parameter int ADDR_W   = 10,
  parameter int STRIDE_W = 4
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [STRIDE_W-1:0] stride,
  input  logic                down,
  output logic [ADDR_W-1:0]   next
);

  logic [ADDR_W-1:0] step;

  assign step = ADDR_W'(stride);
  // Truncation to ADDR_W bits gives the silent wrap in both directions.
  assign next = down ? addr - step : addr + step;

endmodule

// File: rtl/burst_addr_gen.sv
// Read-address generator: latches a (base, len, stride, mode) command and
// issues one address per accepted valid/ready beat.
module burst_addr_gen
  import burst_addr_gen_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int STRIDE_W = STRIDE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base,
  input  logic [LEN_W-1:0]    len,
  input  logic [STRIDE_W-1:0] stride,
  input  logic                abort,
  output logic [ADDR_W-1:0]   raddr,
  output logic                raddr_valid,
  input  logic                raddr_ready,
  output logic                last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(1) << ADDR_W;

  state_e                state, state_nxt;
  mode_e                 mode_q;
  logic [ADDR_W-1:0]     base_q;
  logic [LEN_W-1:0]      len_q;
  logic [STRIDE_W-1:0]   stride_q;
  logic [LEN_W-1:0]      beat_cnt;   // beats already accepted in this pass
  logic [ADDR_W-1:0]     addr_nxt;
  logic                  beat;
  logic                  end_pass;
  logic                  cmd_ok;

  assign cmd_ok   = (len != '0) && ({1'b0, len} <= MAX_LEN) && (mode_e'(mode) != MODE_RSVD);
  assign beat     = raddr_valid & raddr_ready;
  assign last     = raddr_valid & (beat_cnt == len_q - 1'b1);
  assign end_pass = beat & last;
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_FIN);

  addr_step #(
    .ADDR_W   (ADDR_W),
    .STRIDE_W (STRIDE_W)
  ) u_step (
    .addr   (raddr),
    .stride (stride_q),
    .down   (mode_q == MODE_REVERSE),
    .next   (addr_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before any branch; without it, paths
  // that leave it unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (start && cmd_ok) state_nxt = ST_RUN;
        ST_RUN:  if (end_pass && mode_q != MODE_CIRCULAR) state_nxt = ST_FIN;
        ST_FIN:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_ONESHOT;
      base_q      <= '0;
      len_q       <= '0;
      stride_q    <= '0;
      beat_cnt    <= '0;
      raddr       <= '0;
      raddr_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (abort) begin
        // raddr deliberately keeps its value so the consumer can see where it stopped
        raddr_valid <= 1'b0;
        beat_cnt    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (cmd_ok) begin
                mode_q      <= mode_e'(mode);
                base_q      <= base;
                len_q       <= len;
                stride_q    <= stride;
                raddr       <= base;
                raddr_valid <= 1'b1;
                beat_cnt    <= '0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (beat) begin
              if (last) begin
                beat_cnt <= '0;
                if (mode_q == MODE_CIRCULAR) raddr <= base_q;
                else                         raddr_valid <= 1'b0;
              end else begin
                beat_cnt <= beat_cnt + 1'b1;
                raddr    <= addr_nxt;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/burst_addr_gen.md
Name: burst_addr_gen

Overview:
Parametrised read-address generator for the sample/label RAMs. It replaces the free-running read-address incrementer. A command (base, length, stride, mode) is latched on a start pulse. The block then issues one address per accepted beat on a valid/ready interface, with one-shot, circular and reverse walks. It sits between the control FSM and the BRAM read port. Downstream stalls are absorbed without losing or repeating addresses.

Parameters:
ADDR_W, 10, address width; memory depth is 2^ADDR_W (1024)
LEN_W, 11, burst length width; must hold 2^ADDR_W (full-memory burst)
STRIDE_W, 4, stride width, unsigned, 0 allowed (repeat same address)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle command strobe, sampled only in IDLE
mode  in  2  0=ONESHOT, 1=CIRCULAR, 2=REVERSE, 3=reserved
base  in  ADDR_W  first address
len  in  LEN_W  beats per pass, 1..2^ADDR_W
stride  in  STRIDE_W  address step per beat
abort  in  1  terminate current command
raddr  out  ADDR_W  read address
raddr_valid  out  1  raddr is valid
raddr_ready  in  1  consumer accepts raddr this cycle
last  out  1  qualifies the final beat of a pass (valid with raddr_valid)
busy  out  1  command in progress
done  out  1  one-cycle pulse when a ONESHOT/REVERSE command completes
err  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset values: raddr=0, raddr_valid=0, last=0, busy=0, done=0, err=0; FSM=IDLE; internal registers cleared. Reset wins over every other input.
- FSM states are IDLE, RUN, FIN.
- IDLE, start=1 with len in 1..2^ADDR_W and mode!=3:
  - latch mode, base, len and stride;
  - next cycle: RUN, raddr=base, raddr_valid=1, busy=1.
  - Latency from start to first valid is exactly 1 cycle.
- IDLE, start=1 with len=0, len>2^ADDR_W or mode=3: err=1 for one cycle, stay in IDLE, no beats.
- start outside IDLE is ignored. There is no queueing.
- Beat = raddr_valid & raddr_ready in the same cycle.
- While valid & !ready: raddr, last and raddr_valid hold stable.
- Beat count: a beat increments the beat counter.
- Next address on a beat:
  - ONESHOT and CIRCULAR: raddr + stride.
  - REVERSE: raddr - stride.
  - All address arithmetic is modulo 2^ADDR_W; wrap-around is silent (1023+1 -> 0, 0-1 -> 1023).
- last=1 while the presented beat is number len of the current pass.
- End of pass (beat with last=1):
  - ONESHOT/REVERSE: raddr_valid=0, FSM=FIN next cycle.
  - CIRCULAR: counter clears, raddr=base next cycle, raddr_valid stays 1. Continuous, no bubble, until abort.
- FIN: done=1 and busy=0 for one cycle, then IDLE. A start in FIN is ignored.
- abort (any state, highest priority after rst):
  - next cycle IDLE, raddr_valid=0, last=0, busy=0;
  - no done pulse; raddr keeps its value.
  - A beat accepted in the abort cycle counts as delivered.
  - abort and start in the same IDLE cycle: abort wins, no command.
- The stride=0 command is legal: the same address is issued len times.
- len=1: the first beat has last=1.

Decomposition:
- Shared package: mode encodings (MODE_ONESHOT=0, MODE_CIRCULAR=1, MODE_REVERSE=2), FSM state encodings, default ADDR_W/LEN_W constants consistent with the DEPTH=1024 / LOG_DEPTH=10 definitions.
- One natural sub-module, addr_step: a combinational modulo add/sub of stride under the direction bit. The rest (FSM, beat counter, output register) stays in burst_addr_gen.

Test Plan:
- ONESHOT, base=5, len=4, stride=1, ready=1 -> raddr 5,6,7,8 on consecutive cycles; last on 8; done pulse 1 cycle after beat 8; busy low.
- Wrap and stall: ONESHOT, base=1022, len=4, stride=1, ready low on 2nd beat for 3 cycles -> 1022,1023(held 3 cycles stable),0,1; no duplicates or drops.
- CIRCULAR, base=100, len=3, stride=2 -> 100,102,104(last),100,102,104(last)... with no bubble; abort mid-pass -> valid low next cycle, no done.
- REVERSE, base=2, len=4, stride=3 -> 2,1023,1020,1017; last on 1017; done pulse.
- Illegal commands: start with len=0, then with mode=3 -> err pulse each, no valid. Start while busy -> ignored, sequence unchanged.
- Reset mid-RUN (rst during beat 2 of len=10) -> all outputs at reset values next cycle. A fresh start then begins cleanly at its base.
